// File: rtl/ice40_serdes_pkg.sv
// Shared types and constants for the iCE40 SERDES clock generator family.
package ice40_serdes_pkg;

  localparam int CNT_W = 2;

  // Counter value held while stopped: clk_slow is low at this slot.
  localparam logic [CNT_W-1:0] CNT_IDLE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/ice40_serdes_clkgen_if.sv
// Run request and generated-clock outputs of ice40_serdes_clkgen.
// The slave modport is the generator side; master is the consumer side.
interface ice40_serdes_clkgen_if;
  import ice40_serdes_pkg::*;

  logic             en;
  logic             clk_slow;
  logic             sync;
  logic             ready;
  logic [CNT_W-1:0] phase;

  modport master (output en, input clk_slow, input sync, input ready, input phase);
  modport slave  (input en, output clk_slow, output sync, output ready, output phase);

endinterface

// File: rtl/ice40_serdes_clkgen.sv
// Divide-by-4 slow clock with phase-slot sync strobe, glitch-free start/stop.
// Define ICE40_SERDES_CLKGEN_GBUF_EN to route sync through an SB_GB at BEL_GB.
module ice40_serdes_clkgen
  import ice40_serdes_pkg::*;
#(
  parameter int PHASE  = 0,
  parameter     BEL_GB = ""
) (
  input  logic                  clk_fast,
  input  logic                  rst_n,
  ice40_serdes_clkgen_if.slave  bus
);

  if (PHASE < 0 || PHASE > 3) begin : g_bad_phase
    $error("ice40_serdes_clkgen: PHASE must be 0..3");
  end

  localparam logic [CNT_W-1:0] SYNC_SLOT = PHASE[CNT_W-1:0];

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             stop_pend, stop_next;
  logic             clk_slow_q, sync_q, ready_q;
  logic             clk_slow_d, sync_d, ready_d;

  // A stop request seen anywhere in a run is latched so the run always ends
  // at the next 1->2 boundary, even if en comes back before then.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stop_next  = stop_pend;
    case (state)
      IDLE: begin
        stop_next = 1'b0;
        if (bus.en) begin
          state_next = WARM;
          cnt_next   = 2'd3;
        end else begin
          cnt_next   = CNT_IDLE;
        end
      end
      WARM: begin
        stop_next = 1'b0;
        if (bus.en) begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end else begin
          state_next = IDLE;
          cnt_next   = CNT_IDLE;
        end
      end
      RUN: begin
        if ((stop_pend || !bus.en) && cnt == 2'd1) begin
          state_next = IDLE;
          cnt_next   = CNT_IDLE;
          stop_next  = 1'b0;
        end else begin
          cnt_next   = cnt + 2'd1;
          stop_next  = stop_pend || !bus.en;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_IDLE;
        stop_next  = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so each registered output
  // lines up with the registered cnt/state of the same cycle.
  always_comb begin
    clk_slow_d = ~cnt_next[1];
    ready_d    = (state_next == RUN);
    sync_d     = (state_next == RUN) && (cnt_next == SYNC_SLOT);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= CNT_IDLE;
      stop_pend  <= 1'b0;
      clk_slow_q <= 1'b0;
      sync_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      stop_pend  <= stop_next;
      clk_slow_q <= clk_slow_d;
      sync_q     <= sync_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.clk_slow = clk_slow_q;
  assign bus.ready    = ready_q;
  assign bus.phase    = cnt;

`ifdef ICE40_SERDES_CLKGEN_GBUF_EN
  (* BEL = BEL_GB *)
  SB_GB u_sync_gb (
    .USER_SIGNAL_TO_GLOBAL_BUFFER (sync_q),
    .GLOBAL_BUFFER_OUTPUT         (bus.sync)
  );
`else
  // Placement only matters when the global buffer is instantiated.
  if (BEL_GB != "") begin : g_bel_unused
  end
  assign bus.sync = sync_q;
`endif

endmodule

// File: tb/tb_ice40_serdes_clkgen.sv
// Directed self-checking bench for ice40_serdes_clkgen, one instance per PHASE.
module tb_ice40_serdes_clkgen;
  import ice40_serdes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [3:0] sync_v, ready_v, clk_slow_v;
  logic [1:0] phase_v [4];

  int check_count = 0;
  int fail_count  = 0;
  int hi_run      = 0;
  int exp_phase;
  int sync_seen [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ice40_serdes_clkgen_if bus ();
    assign bus.en        = en;
    assign sync_v[g]     = bus.sync;
    assign ready_v[g]    = bus.ready;
    assign clk_slow_v[g] = bus.clk_slow;
    assign phase_v[g]    = bus.phase;

    ice40_serdes_clkgen #(.PHASE(g)) dut (
      .clk_fast (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave)
    );
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_val);
    en = en_val;
  endtask

  // Advance one fast cycle and sample just after the edge; completed
  // clk_slow high pulses of the PHASE=1 instance must be exactly 2 long.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (clk_slow_v[1]) begin
      hi_run++;
    end else if (hi_run != 0) begin
      checkOutput("hi_len", hi_run, 2);
      hi_run = 0;
    end
  endtask

  task automatic check_main(input string tag, input int ph, input int cs, input int rd, input int sy);
    checkOutput({tag, ".phase"}, phase_v[1], ph);
    checkOutput({tag, ".clk_slow"}, clk_slow_v[1], cs);
    checkOutput({tag, ".ready"}, ready_v[1], rd);
    checkOutput({tag, ".sync"}, sync_v[1], sy);
  endtask

  initial begin
    int clk_tab [8];
    int ph_tab [8];
    clk_tab = '{0, 0, 1, 1, 0, 0, 1, 1};
    ph_tab  = '{2, 3, 0, 1, 2, 3, 0, 1};

    rst_n = 1'b0;
    applyStimulus(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_main("reset", 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("reset_sync%0d", k), sync_v[k], 0);
    rst_n = 1'b1;
    step_cycle();
    check_main("idle", 2, 0, 0, 0);

    applyStimulus(1'b1);
    step_cycle();
    check_main("start_warm", 3, 0, 0, 0);
    step_cycle();
    check_main("start_run", 0, 1, 1, 0);
    step_cycle();
    check_main("start_sync", 1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step_cycle();
      checkOutput($sformatf("pattern%0d.clk_slow", i), clk_slow_v[1], clk_tab[i]);
      checkOutput($sformatf("pattern%0d.phase", i), phase_v[1], ph_tab[i]);
    end

    exp_phase = 1;
    for (int k = 0; k < 4; k++) sync_seen[k] = 0;
    for (int i = 0; i < 80; i++) begin
      step_cycle();
      exp_phase = (exp_phase + 1) % 4;
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("sweep%0d.phase", k), phase_v[k], exp_phase);
        checkOutput($sformatf("sweep%0d.sync", k), sync_v[k], (exp_phase == k) ? 1 : 0);
        sync_seen[k] += int'(sync_v[k]);
      end
    end
    for (int k = 0; k < 4; k++) checkOutput($sformatf("sweep%0d.count", k), sync_seen[k], 20);

    repeat (3) step_cycle();
    check_main("stop_at0", 0, 1, 1, 0);
    applyStimulus(1'b0);
    step_cycle();
    check_main("stop_pulse", 1, 1, 1, 1);
    step_cycle();
    check_main("stop_idle", 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("stopped%0d.sync", k), sync_v[k], 0);
        checkOutput($sformatf("stopped%0d.phase", k), phase_v[k], 2);
      end
      checkOutput("stopped.clk_slow", clk_slow_v[1], 0);
    end

    applyStimulus(1'b1);
    step_cycle();
    check_main("abort_warm", 3, 0, 0, 0);
    applyStimulus(1'b0);
    step_cycle();
    check_main("abort_idle", 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput("abort.clk_slow", clk_slow_v[1], 0);
      checkOutput("abort.sync", sync_v[1], 0);
    end

    applyStimulus(1'b1);
    step_cycle();
    check_main("rerun_warm", 3, 0, 0, 0);
    repeat (4) step_cycle();
    step_cycle();
    check_main("rerun_at0", 0, 1, 1, 0);
    rst_n = 1'b0;
    hi_run = 0;
    #1;
    check_main("midreset", 2, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_main("midreset_hold", 2, 0, 0, 0);
    step_cycle();
    check_main("restart_warm", 3, 0, 0, 0);
    step_cycle();
    check_main("restart_run", 0, 1, 1, 0);
    step_cycle();
    check_main("restart_sync", 1, 1, 1, 1);

    step_cycle();
    step_cycle();
    check_main("race_at3", 3, 0, 1, 0);
    applyStimulus(1'b0);
    step_cycle();
    check_main("race_p0", 0, 1, 1, 0);
    step_cycle();
    check_main("race_p1", 1, 1, 1, 1);
    applyStimulus(1'b1);
    step_cycle();
    check_main("race_idle", 2, 0, 0, 0);
    step_cycle();
    check_main("race_warm", 3, 0, 0, 0);
    step_cycle();
    check_main("race_run", 0, 1, 1, 0);
    step_cycle();
    check_main("race_sync", 1, 1, 1, 1);
    step_cycle();
    check_main("race_low", 2, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
